// File: rtl/wr_demux16_pkg.sv
// Shared types and sizes for the write-side bank demux.
package wr_demux16_pkg;

  typedef enum logic {IDLE, CLEAR} wr_state_t;

  localparam int NUM_ENTRIES = 16;
  localparam int ADDR_W      = 4;

endpackage

// File: rtl/wr_demux16_dec.sv
// Purpose: 4-to-16 one-hot decoder, structural inverse of the read-side mux16_1.
// Latency: combinational.
// Backpressure: none.
module dec4_16 (
  input  logic [3:0]  in,
  output logic [15:0] out
);

  always_comb begin
    out = 16'h0001 << in;
  end

endmodule

// File: rtl/wr_demux16.sv
// Purpose: steer accepted writes onto a registered one-hot wen/wdata bus; bulk-clear walks entries 0..15.
// Latency: 1 cycle from accept edge to wen/wdata; clear occupies 16 consecutive cycles.
// Backpressure: wr_ready drops while clearing or when a clear is requested; held requests are not recorded.
module wr_demux16
  import wr_demux16_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic [NUM_ENTRIES-1:0] wen,
  output logic [WIDTH-1:0]       wdata
);

  wr_state_t              state;
  logic [ADDR_W-1:0]      cnt;
  logic [ADDR_W-1:0]      dec_sel;
  logic [NUM_ENTRIES-1:0] dec_out;

  assign wr_ready = (state == IDLE) && !clr_req;

  // A clear starting from IDLE always issues entry 0 first.
  always_comb begin
    dec_sel = wr_addr;
    if (state == CLEAR) begin
      dec_sel = cnt;
    end else if (clr_req) begin
      dec_sel = '0;
    end
  end

  dec4_16 u_dec (
    .in  (dec_sel),
    .out (dec_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      wen      <= '0;
      wdata    <= '0;
      clr_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            wen      <= dec_out;
            wdata    <= '0;
            clr_busy <= 1'b1;
            cnt      <= 4'd1;
          end else if (wr_valid) begin
            wen      <= dec_out;
            wdata    <= wr_data;
            clr_busy <= 1'b0;
          end else begin
            wen      <= '0;
            clr_busy <= 1'b0;
          end
        end
        CLEAR: begin
          wen      <= dec_out;
          wdata    <= '0;
          clr_busy <= 1'b1;
          cnt      <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          wen      <= '0;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
